pe_multi_filter_conv: RTL and testbench

- Next-generation 1-D convolution PE. Applies up to NUM_FILTERS filters to one buffered ifmap row with a runtime stride.
- Each ifmap row is loaded once and reused across all filters. Filters may be kept across rows (reuse_filt).
- Sits between the ifmap/filter input FIFOs and the psum collector.
- Uses ready/valid handshakes on every stream, plus a 3-stage read/multiply/accumulate pipeline with output-FIFO backpressure.

---
 rtl/pe_multi_filter_conv.sv | 244 ++++++++++++++++++++++++
 tb/tb_pe_multi_filter_conv.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_multi_filter_conv.sv
// Multi-filter 1-D convolution PE. One buffered ifmap row is reused across up to
// NUM_FILTERS filter banks with a runtime stride; a 3-stage MAC pipeline feeds a psum FIFO.
module pe_multi_filter_conv #(
    parameter int DATA_W      = 16,
    parameter int FILT_W      = 8,
    parameter int PSUM_W      = 16,
    parameter int ROW_DEPTH   = 12,
    parameter int MAX_FS      = 8,
    parameter int NUM_FILTERS = 4,
    parameter int STRIDE_W    = 3,
    parameter int OUT_DEPTH   = 8,
    localparam int FSW  = $clog2(MAX_FS + 1),
    localparam int NFW  = $clog2(NUM_FILTERS + 1),
    localparam int FIDW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_ld,
    input  logic [STRIDE_W-1:0] cfg_stride,
    input  logic [FSW-1:0]      cfg_fs,
    input  logic [NFW-1:0]      cfg_nf,
    input  logic                start,
    input  logic                reuse_filt,
    input  logic                filt_valid,
    output logic                filt_ready,
    input  logic [FILT_W-1:0]   filt_data,
    input  logic                ifm_valid,
    output logic                ifm_ready,
    input  logic [DATA_W-1:0]   ifm_data,
    input  logic                ifm_last,
    output logic                psum_valid,
    input  logic                psum_ready,
    output logic [PSUM_W-1:0]   psum_data,
    output logic [FIDW-1:0]     psum_fid,
    output logic                busy,
    output logic                done
);
    localparam int AW  = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;
    localparam int LW  = $clog2(ROW_DEPTH + 1);
    localparam int TW  = (MAX_FS > 1) ? $clog2(MAX_FS) : 1;
    localparam int QAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int QW  = $clog2(OUT_DEPTH + 1);
    localparam int PW  = DATA_W + FILT_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_FILT, S_LOAD_ROW, S_COMPUTE, S_FLUSH} state_t;

    state_t              state_q;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [FSW-1:0]      fs_q, fs_d;
    logic [NFW-1:0]      nf_q, nf_d;
    logic [NFW-1:0]      fb_q, f_q;
    logic [FSW-1:0]      ft_q, k_q;
    logic [LW-1:0]       wa_q, len_q, base_q;
    logic                done_q;

    logic [FILT_W-1:0]   filt_mem [NUM_FILTERS][MAX_FS];
    logic [DATA_W-1:0]   ifm_mem  [ROW_DEPTH];

    logic                room, grp_start, issue, tap_last, filt_last, win_last;
    logic [AW-1:0]       rd_addr;

    logic [1:0]          vld_pipe_q;
    logic                s0_k0_q, s0_last_q, s1_k0_q, s1_last_q;
    logic [FIDW-1:0]     s0_fid_q, s1_fid_q;
    logic [DATA_W-1:0]   ifm_rd_q;
    logic [FILT_W-1:0]   filt_rd_q;
    logic [PW-1:0]       prod_full;
    logic [PSUM_W-1:0]   prod_q, acc_q, acc_d;

    logic [PSUM_W-1:0]   fifo_data [OUT_DEPTH];
    logic [FIDW-1:0]     fifo_fid  [OUT_DEPTH];
    logic [QAW-1:0]      wp_q, rp_q;
    logic [QW-1:0]       cnt_q, infl_q;
    logic                push, pop;

    always_comb begin
        stride_d = (cfg_stride == '0) ? STRIDE_W'(1) : cfg_stride;
        fs_d = cfg_fs;
        if (cfg_fs == '0)                  fs_d = FSW'(1);
        else if (int'(cfg_fs) > MAX_FS)    fs_d = FSW'(MAX_FS);
        nf_d = cfg_nf;
        if (cfg_nf == '0)                  nf_d = NFW'(1);
        else if (int'(cfg_nf) > NUM_FILTERS) nf_d = NFW'(NUM_FILTERS);
    end

    // Admission counts groups already issued but not yet pushed, so an issued group always has a slot.
    always_comb begin
        room      = (int'(cnt_q) + int'(infl_q)) < OUT_DEPTH;
        grp_start = (k_q == '0);
        issue     = (state_q == S_COMPUTE) && (!grp_start || room);
        tap_last  = (k_q == fs_q - FSW'(1));
        filt_last = (f_q == nf_q - NFW'(1));
        win_last  = (int'(base_q) + int'(stride_q) + int'(fs_q)) > int'(len_q);
        rd_addr   = AW'(int'(base_q) + int'(k_q));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            stride_q <= STRIDE_W'(1);
            fs_q     <= FSW'(1);
            nf_q     <= NFW'(1);
            fb_q     <= '0;
            ft_q     <= '0;
            wa_q     <= '0;
            len_q    <= '0;
            base_q   <= '0;
            f_q      <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_ld) begin
                        stride_q <= stride_d;
                        fs_q     <= fs_d;
                        nf_q     <= nf_d;
                    end
                    if (start) begin
                        fb_q    <= '0;
                        ft_q    <= '0;
                        wa_q    <= '0;
                        state_q <= reuse_filt ? S_LOAD_ROW : S_LOAD_FILT;
                    end
                end
                S_LOAD_FILT: if (filt_valid) begin
                    if (ft_q == fs_q - FSW'(1)) begin
                        ft_q <= '0;
                        fb_q <= fb_q + NFW'(1);
                        if (fb_q == nf_q - NFW'(1)) state_q <= S_LOAD_ROW;
                    end else begin
                        ft_q <= ft_q + FSW'(1);
                    end
                end
                S_LOAD_ROW: if (ifm_valid) begin
                    wa_q <= wa_q + LW'(1);
                    if (ifm_last || wa_q == LW'(ROW_DEPTH - 1)) begin
                        len_q   <= wa_q + LW'(1);
                        base_q  <= '0;
                        f_q     <= '0;
                        k_q     <= '0;
                        state_q <= (int'(wa_q) + 1 >= int'(fs_q)) ? S_COMPUTE : S_FLUSH;
                    end
                end
                S_COMPUTE: if (issue) begin
                    if (tap_last) begin
                        k_q <= '0;
                        if (filt_last) begin
                            f_q    <= '0;
                            base_q <= base_q + LW'(stride_q);
                            if (win_last) state_q <= S_FLUSH;
                        end else begin
                            f_q <= f_q + NFW'(1);
                        end
                    end else begin
                        k_q <= k_q + FSW'(1);
                    end
                end
                S_FLUSH: if (vld_pipe_q == '0) begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD_FILT && filt_valid)
            filt_mem[fb_q[FIDW-1:0]][ft_q[TW-1:0]] <= filt_data;
        if (state_q == S_LOAD_ROW && ifm_valid)
            ifm_mem[wa_q[AW-1:0]] <= ifm_data;
        ifm_rd_q  <= ifm_mem[rd_addr];
        filt_rd_q <= filt_mem[f_q[FIDW-1:0]][k_q[TW-1:0]];
    end

    assign prod_full = {{FILT_W{1'b0}}, ifm_rd_q} * {{DATA_W{1'b0}}, filt_rd_q};
    assign acc_d     = s1_k0_q ? prod_q : acc_q + prod_q;
    assign push      = vld_pipe_q[1] && s1_last_q;
    assign pop       = psum_valid && psum_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_q <= '0;
            s0_k0_q    <= 1'b0;
            s0_last_q  <= 1'b0;
            s0_fid_q   <= '0;
            s1_k0_q    <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_fid_q   <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], issue};
            s0_k0_q    <= grp_start;
            s0_last_q  <= tap_last;
            s0_fid_q   <= f_q[FIDW-1:0];
            s1_k0_q    <= s0_k0_q;
            s1_last_q  <= s0_last_q;
            s1_fid_q   <= s0_fid_q;
            prod_q     <= PSUM_W'(prod_full);
            if (vld_pipe_q[1]) acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wp_q] <= acc_d;
            fifo_fid[wp_q]  <= s1_fid_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            infl_q <= '0;
        end else begin
            if (push) wp_q <= (wp_q == QAW'(OUT_DEPTH - 1)) ? '0 : wp_q + QAW'(1);
            if (pop)  rp_q <= (rp_q == QAW'(OUT_DEPTH - 1)) ? '0 : rp_q + QAW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + QW'(1);
                2'b01:   cnt_q <= cnt_q - QW'(1);
                default: cnt_q <= cnt_q;
            endcase
            case ({issue && grp_start, push})
                2'b10:   infl_q <= infl_q + QW'(1);
                2'b01:   infl_q <= infl_q - QW'(1);
                default: infl_q <= infl_q;
            endcase
        end
    end

    assign psum_valid = (cnt_q != '0);
    assign psum_data  = psum_valid ? fifo_data[rp_q] : '0;
    assign psum_fid   = psum_valid ? fifo_fid[rp_q] : '0;
    assign busy       = (state_q != S_IDLE);
    assign filt_ready = (state_q == S_LOAD_FILT);
    assign ifm_ready  = (state_q == S_LOAD_ROW);
    assign done       = done_q;

endmodule

// File: tb/tb_pe_multi_filter_conv.sv
// Directed bench for pe_multi_filter_conv: a plain-arithmetic convolution model
// queues expected psums, and a single negedge process scores every pop.
module tb_pe_multi_filter_conv;
    localparam int DATA_W = 16, FILT_W = 8, PSUM_W = 16, ROW_DEPTH = 12, MAX_FS = 8;
    localparam int NUM_FILTERS = 4, STRIDE_W = 3, OUT_DEPTH = 8;
    localparam int FSW = 4, NFW = 3, FIDW = 2;

    logic clk = 1'b0, rstn = 1'b0;
    logic cfg_ld = 0, start = 0, reuse_filt = 0;
    logic [STRIDE_W-1:0] cfg_stride = '0;
    logic [FSW-1:0] cfg_fs = '0;
    logic [NFW-1:0] cfg_nf = '0;
    logic filt_valid = 0, filt_ready;
    logic [FILT_W-1:0] filt_data = '0;
    logic ifm_valid = 0, ifm_ready, ifm_last = 0;
    logic [DATA_W-1:0] ifm_data = '0;
    logic psum_valid, psum_ready = 1'b1;
    logic [PSUM_W-1:0] psum_data;
    logic [FIDW-1:0] psum_fid;
    logic busy, done;

    pe_multi_filter_conv #(
        .DATA_W(DATA_W), .FILT_W(FILT_W), .PSUM_W(PSUM_W), .ROW_DEPTH(ROW_DEPTH), .MAX_FS(MAX_FS),
        .NUM_FILTERS(NUM_FILTERS), .STRIDE_W(STRIDE_W), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_ld(cfg_ld), .cfg_stride(cfg_stride), .cfg_fs(cfg_fs),
        .cfg_nf(cfg_nf), .start(start), .reuse_filt(reuse_filt), .filt_valid(filt_valid),
        .filt_ready(filt_ready), .filt_data(filt_data), .ifm_valid(ifm_valid),
        .ifm_ready(ifm_ready), .ifm_data(ifm_data), .ifm_last(ifm_last),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .psum_fid(psum_fid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int fid; int val; } exp_t;
    exp_t exp_q[$];
    int checks = 0, failures = 0, npop = 0, done_cnt = 0, cyc = 0, rdy_mode = 0;
    bit done_pv = 0, reuse_phase = 0, saw_fr = 0;
    int m_row[16];
    int m_filt[4][8];
    int c_stride = 1, c_fs = 1, c_nf = 1, b_stride = 1, b_fs = 1, b_nf = 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: W windows, each filter dotted against the window, summed modulo 2^PSUM_W.
    task automatic model_row(input int n);
        int L, W;
        longint s;
        exp_t e;
        L = (n > ROW_DEPTH) ? ROW_DEPTH : n;
        W = (L < b_fs) ? 0 : (L - b_fs) / b_stride + 1;
        for (int w = 0; w < W; w++)
            for (int f = 0; f < b_nf; f++) begin
                s = 0;
                for (int k = 0; k < b_fs; k++)
                    s += longint'(m_row[w*b_stride+k]) * longint'(m_filt[f][k]);
                e.fid = f;
                e.val = int'(s % 65536);
                exp_q.push_back(e);
            end
    endtask

    task automatic pin(input string name, input int idx, input int fid, input int val);
        if (idx >= exp_q.size()) begin
            checks++; failures++;
            $display("FAIL %s model_len=%0d required_index=%0d", name, exp_q.size(), idx);
        end else begin
            chk({name, "_fid"}, exp_q[idx].fid, fid);
            chk({name, "_val"}, exp_q[idx].val, val);
        end
    endtask

    task automatic set_cfg(input int s, input int fs, input int nf);
        c_stride = s; c_fs = fs; c_nf = nf;
        b_stride = (s == 0) ? 1 : s;
        b_fs = (fs == 0) ? 1 : ((fs > MAX_FS) ? MAX_FS : fs);
        b_nf = (nf == 0) ? 1 : ((nf > NUM_FILTERS) ? NUM_FILTERS : nf);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic xfer_filt(input int w, output bit ok);
        bit acc;
        int t;
        filt_valid = 1; filt_data = FILT_W'(w); ok = 0; t = 0;
        while (!ok && t < 10) begin
            @(negedge clk); acc = filt_ready;
            tick(); ok = acc; t++;
        end
        filt_valid = 0;
    endtask

    task automatic xfer_ifm(input int d, input bit last, output bit ok);
        bit acc;
        int t;
        ifm_valid = 1; ifm_data = DATA_W'(d); ifm_last = last; ok = 0; t = 0;
        while (!ok && t < 8) begin
            @(negedge clk); acc = ifm_ready;
            tick(); ok = acc; t++;
        end
        ifm_valid = 0; ifm_last = 0;
    endtask

    task automatic go(input bit ld, input bit reuse, input int nwords, input bit use_last, output int accepted);
        bit ok;
        cfg_ld = ld; cfg_stride = STRIDE_W'(c_stride); cfg_fs = FSW'(c_fs); cfg_nf = NFW'(c_nf);
        start = 1; reuse_filt = reuse; reuse_phase = reuse;
        tick();
        cfg_ld = 0; start = 0; reuse_filt = 0;
        if (!reuse)
            for (int i = 0; i < b_nf * b_fs; i++) begin
                xfer_filt(m_filt[i/b_fs][i%b_fs], ok);
                if (!ok) chk("filt_accept", 0, 1);
            end
        accepted = 0;
        for (int i = 0; i < nwords; i++) begin
            xfer_ifm(m_row[i], use_last && (i == nwords - 1), ok);
            if (!ok) break;
            accepted++;
        end
    endtask

    task automatic wait_done(input int prev, input string name);
        int t = 0;
        while (done_cnt == prev && t < 3000) begin tick(); t++; end
        chk({name, "_done_seen"}, done_cnt - prev, 1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin tick(); t++; end
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       psum_ready = 1'b1;
            1:       psum_ready = 1'b0;
            default: psum_ready = (cyc % 4 == 0);
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done) begin done_cnt++; done_pv = psum_valid; end
        if (reuse_phase && filt_ready) saw_fr = 1;
        if (rstn && psum_valid && psum_ready) begin
            npop++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL psum_extra actual fid=%0d data=%0d required none", psum_fid, psum_data);
            end else begin
                e = exp_q.pop_front();
                if (int'(psum_data) != e.val || int'(psum_fid) != e.fid) begin
                    failures++;
                    $display("FAIL psum actual %0d:%0d required %0d:%0d", psum_fid, psum_data, e.fid, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, acc, np;
        int lit1[8] = '{6, 7, 9, 10, 12, 13, 15, 16};
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_psum_valid", psum_valid, 0);
        chk("rst_psum_data", psum_data, 0);
        chk("rst_filt_ready", filt_ready, 0);
        chk("rst_ifm_ready", ifm_ready, 0);
        rstn = 1;
        tick();

        // Row 1: fs=3 stride=1 nf=2, config loaded together with start
        m_filt[0][0] = 1; m_filt[0][1] = 1; m_filt[0][2] = 1;
        m_filt[1][0] = 1; m_filt[1][1] = 0; m_filt[1][2] = 2;
        for (int i = 0; i < 6; i++) m_row[i] = i + 1;
        set_cfg(1, 3, 2);
        model_row(6);
        chk("t1_model_len", exp_q.size(), 8);
        for (int i = 0; i < 8; i++) pin("t1_pin", i, i % 2, lit1[i]);
        prev = done_cnt;
        go(1, 0, 6, 1, acc);
        chk("t1_row_len", acc, 6);
        wait_done(prev, "t1");
        drain("t1");
        repeat (5) tick();
        chk("t1_done_once", done_cnt - prev, 1);
        chk("t1_idle", busy, 0);

        // Stride 2, same data and filters
        set_cfg(2, 3, 2);
        model_row(6);
        chk("t2_model_len", exp_q.size(), 4);
        pin("t2_p0", 0, 0, 6); pin("t2_p1", 1, 1, 7);
        pin("t2_p2", 2, 0, 12); pin("t2_p3", 3, 1, 13);
        prev = done_cnt;
        go(1, 1, 6, 1, acc);
        wait_done(prev, "t2");
        drain("t2");

        // Second row 2..7 with filter reuse
        for (int i = 0; i < 6; i++) m_row[i] = i + 2;
        set_cfg(1, 3, 2);
        model_row(6);
        pin("t3_p0", 0, 0, 9); pin("t3_p1", 1, 1, 10);
        saw_fr = 0;
        prev = done_cnt;
        go(1, 1, 6, 1, acc);
        wait_done(prev, "t3");
        drain("t3");
        chk("t3_no_filt_ready", saw_fr, 0);
        reuse_phase = 0;

        // Backpressure: nf=4, W=4, psum_ready low for 50 cycles
        m_filt[2][0] = 2; m_filt[2][1] = 1; m_filt[2][2] = 0;
        m_filt[3][0] = 3; m_filt[3][1] = 3; m_filt[3][2] = 3;
        for (int i = 0; i < 6; i++) m_row[i] = i + 1;
        set_cfg(1, 3, 4);
        model_row(6);
        chk("t4_model_len", exp_q.size(), 16);
        pin("t4_p2", 2, 2, 4); pin("t4_p3", 3, 3, 18); pin("t4_p15", 15, 3, 45);
        rdy_mode = 1;
        prev = done_cnt;
        go(1, 0, 6, 1, acc);
        repeat (50) tick();
        chk("t4_fifo_full", dut.cnt_q, 8);
        chk("t4_stalled_busy", busy, 1);
        chk("t4_no_done_yet", done_cnt - prev, 0);
        chk("t4_valid_held", psum_valid, 1);
        rdy_mode = 2;
        wait_done(prev, "t4");
        chk("t4_done_before_last_pop", done_pv, 1);
        drain("t4");
        rdy_mode = 0;

        // Short row: L < fs gives no psums
        set_cfg(1, 3, 4);
        model_row(2);
        chk("t5_model_empty", exp_q.size(), 0);
        np = npop;
        prev = done_cnt;
        go(0, 1, 2, 1, acc);
        chk("t5_row_len", acc, 2);
        wait_done(prev, "t5");
        repeat (10) tick();
        chk("t5_no_psums", npop - np, 0);
        reuse_phase = 0;

        // 14 words without last: row capped at ROW_DEPTH
        for (int i = 0; i < 14; i++) m_row[i] = i + 1;
        set_cfg(1, 3, 1);
        model_row(14);
        chk("t6_model_len", exp_q.size(), 10);
        pin("t6_p9", 9, 0, 33);
        prev = done_cnt;
        go(1, 1, 14, 0, acc);
        chk("t6_accepted", acc, 12);
        chk("t6_ifm_ready_low", ifm_ready, 0);
        wait_done(prev, "t6");
        drain("t6");
        reuse_phase = 0;

        // Overflow: 8 taps of 0xFFFF * 0xFF wrap modulo 2^16
        for (int i = 0; i < 8; i++) begin m_filt[0][i] = 255; m_row[i] = 65535; end
        set_cfg(1, 8, 1);
        model_row(8);
        pin("t7_wrap", 0, 0, 32'hF808);
        prev = done_cnt;
        go(1, 0, 8, 1, acc);
        wait_done(prev, "t7");
        drain("t7");

        // Asynchronous reset in the middle of compute
        for (int i = 0; i < 12; i++) m_row[i] = i + 1;
        set_cfg(1, 3, 4);
        model_row(12);
        go(1, 1, 12, 1, acc);
        repeat (6) tick();
        chk("t8_in_compute", busy, 1);
        #2 rstn = 0;
        #1;
        chk("t8_rst_busy", busy, 0);
        chk("t8_rst_psum_valid", psum_valid, 0);
        chk("t8_rst_ifm_ready", ifm_ready, 0);
        chk("t8_rst_done", done, 0);
        exp_q.delete();
        reuse_phase = 0;
        tick(); tick();
        rstn = 1;
        tick();

        // Post-reset defaults: stride 1, fs 1, nf 1 without loading config
        m_filt[0][0] = 3; m_row[0] = 5; m_row[1] = 6;
        set_cfg(1, 1, 1);
        model_row(2);
        pin("t9_p0", 0, 0, 15); pin("t9_p1", 1, 0, 18);
        prev = done_cnt;
        go(0, 0, 2, 1, acc);
        wait_done(prev, "t9");
        drain("t9");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
